// File: rtl/throw_scheduler_if.sv
// rtl/throw_scheduler_if.sv - pattern/control/event bundle for throw_scheduler (THROW_COUNT_EN adds throw_count_out)
interface throw_scheduler_if;
  logic [6:0][2:0] pattern_in;
  logic [2:0]      pattern_length;
  logic            pattern_valid_in;
  logic            start_in;
  logic            stop_in;
  logic            beat_in;
  logic            busy_out;
  logic [2:0]      num_balls_out;
  logic            event_valid_out;
  logic [2:0]      throw_height_out;
  logic [2:0]      ball_id_out;
  logic            hand_out;
  logic            error_out;
`ifdef THROW_COUNT_EN
  logic [15:0]     throw_count_out;
`endif

  modport master (
    output pattern_in, pattern_length, pattern_valid_in, start_in, stop_in, beat_in,
    input  busy_out, num_balls_out, event_valid_out, throw_height_out, ball_id_out,
           hand_out, error_out
`ifdef THROW_COUNT_EN
  , input  throw_count_out
`endif
  );

  modport slave (
    input  pattern_in, pattern_length, pattern_valid_in, start_in, stop_in, beat_in,
    output busy_out, num_balls_out, event_valid_out, throw_height_out, ball_id_out,
           hand_out, error_out
`ifdef THROW_COUNT_EN
  , output throw_count_out
`endif
  );
endinterface

// File: rtl/throw_scheduler.sv
// rtl/throw_scheduler.sv - siteswap player: latch pattern, derive ball count, emit one throw per beat
// Optional THROW_COUNT_EN macro adds a 16-bit count of nonzero throws.
module throw_scheduler (
  input  logic              clk_in,
  input  logic              rst_in,
  throw_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SUM, DIV, RUN} state_t;

  state_t          state_q, next_state;
  logic [6:0][2:0] pat_q;
  logic [2:0]      len_q, idx_q, quot_q, pos_q, cur_q, fresh_q, next_hand_q;
  logic [5:0]      sum_q;
  logic [7:0]      tbl_valid;
  logic [7:0][2:0] tbl_id;
  logic [2:0]      num_balls_q, height_q, ball_q;
  logic            hand_q, event_q, error_q;

  logic            start_ok, do_beat, h_nz, use_fresh, beat_err;
  logic [2:0]      h, target, ball;

  assign start_ok = bus.start_in && bus.pattern_valid_in && (bus.pattern_length != 3'd0);
  assign do_beat  = (state_q == RUN) && bus.beat_in && !bus.stop_in;

  always_comb begin
    h         = pat_q[pos_q];
    h_nz      = (h != 3'd0);
    target    = cur_q + h;
    use_fresh = h_nz && !tbl_valid[cur_q];
    ball      = 3'd0;
    if (h_nz)
      ball = tbl_valid[cur_q] ? tbl_id[cur_q] : fresh_q;
    beat_err  = (use_fresh && (fresh_q >= num_balls_q)) ||
                (!h_nz && tbl_valid[cur_q]) ||
                (h_nz && tbl_valid[target]);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    if (bus.stop_in) begin
      next_state = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_ok) next_state = SUM;
        SUM:     if (idx_q == len_q - 3'd1) next_state = DIV;
        DIV:     if (sum_q < {3'b000, len_q}) next_state = RUN;
        RUN:     next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // sum_q doubles as the running remainder during DIV
  always_ff @(posedge clk_in) begin
    event_q <= 1'b0;
    error_q <= 1'b0;
    if (rst_in) begin
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      quot_q      <= '0;
      pos_q       <= '0;
      cur_q       <= '0;
      fresh_q     <= '0;
      next_hand_q <= '0;
      tbl_valid   <= '0;
      tbl_id      <= '0;
      num_balls_q <= '0;
      height_q    <= '0;
      ball_q      <= '0;
      hand_q      <= 1'b0;
    end else if (bus.stop_in) begin
      tbl_valid <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            pat_q       <= bus.pattern_in;
            len_q       <= bus.pattern_length;
            idx_q       <= '0;
            sum_q       <= '0;
            quot_q      <= '0;
            pos_q       <= '0;
            cur_q       <= '0;
            fresh_q     <= '0;
            next_hand_q <= '0;
            tbl_valid   <= '0;
            num_balls_q <= '0;
          end else if (bus.start_in) begin
            error_q <= 1'b1;
          end
        end
        SUM: begin
          sum_q <= sum_q + {3'b000, pat_q[idx_q]};
          idx_q <= idx_q + 3'd1;
        end
        DIV: begin
          if (sum_q >= {3'b000, len_q}) begin
            sum_q  <= sum_q - {3'b000, len_q};
            quot_q <= quot_q + 3'd1;
          end else begin
            num_balls_q <= quot_q;
          end
        end
        RUN: begin
          if (bus.beat_in) begin
            height_q    <= h;
            ball_q      <= ball;
            hand_q      <= next_hand_q[0];
            next_hand_q <= {2'b00, ~next_hand_q[0]};
            event_q     <= 1'b1;
            error_q     <= beat_err;
            if (h_nz) begin
              tbl_valid[cur_q]  <= 1'b0;
              tbl_valid[target] <= 1'b1;
              tbl_id[target]    <= ball;
            end
            if (use_fresh) fresh_q <= fresh_q + 3'd1;
            cur_q <= cur_q + 3'd1;
            pos_q <= (pos_q == len_q - 3'd1) ? 3'd0 : pos_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_out         = (state_q != IDLE);
  assign bus.num_balls_out    = num_balls_q;
  assign bus.event_valid_out  = event_q;
  assign bus.throw_height_out = height_q;
  assign bus.ball_id_out      = ball_q;
  assign bus.hand_out         = hand_q;
  assign bus.error_out        = error_q;

`ifdef THROW_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge clk_in) begin
    if (rst_in || bus.stop_in)
      count_q <= '0;
    else if (state_q == IDLE && start_ok)
      count_q <= '0;
    else if (do_beat && h_nz)
      count_q <= count_q + 16'd1;
  end
  assign bus.throw_count_out = count_q;
`endif
endmodule

// File: tb/tb_throw_scheduler.sv
// tb/tb_throw_scheduler.sv - directed-vector self-checking bench for throw_scheduler
module tb_throw_scheduler;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  throw_scheduler_if bus();

  throw_scheduler dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_pat(input string tag, input logic [6:0][2:0] p, input logic [2:0] len,
                           input int exp_n);
    bus.pattern_in       = p;
    bus.pattern_length   = len;
    bus.pattern_valid_in = 1'b1;
    bus.start_in         = 1'b1;
    tick;
    bus.start_in = 1'b0;
    check({tag, "_busy"}, int'(bus.busy_out), 1);
    repeat (int'(len) + exp_n + 1) tick;
    check({tag, "_num_balls"}, int'(bus.num_balls_out), exp_n);
  endtask

  task automatic beat(input string tag, input int h, input int id, input int hand, input int err);
    bus.beat_in = 1'b1;
    tick;
    bus.beat_in = 1'b0;
    check({tag, "_event"},  int'(bus.event_valid_out), 1);
    check({tag, "_height"}, int'(bus.throw_height_out), h);
    check({tag, "_id"},     int'(bus.ball_id_out), id);
    check({tag, "_hand"},   int'(bus.hand_out), hand);
    check({tag, "_error"},  int'(bus.error_out), err);
  endtask

  task automatic stop_play;
    bus.stop_in = 1'b1;
    tick;
    bus.stop_in = 1'b0;
  endtask

  logic [6:0][2:0] p3, p531, p40, p21;
  int ids3[7]   = '{0, 1, 2, 0, 1, 2, 0};
  int ids531[7] = '{0, 1, 2, 2, 1, 0, 0};
  int hs531[7]  = '{5, 3, 1, 5, 3, 1, 5};
  int hs40[5]   = '{4, 0, 4, 0, 4};
  int ids40[5]  = '{0, 0, 1, 0, 0};

  initial begin
    p3   = '0; p3[0] = 3'd3;
    p531 = '0; p531[0] = 3'd5; p531[1] = 3'd3; p531[2] = 3'd1;
    p40  = '0; p40[0] = 3'd4;
    p21  = '0; p21[0] = 3'd2; p21[1] = 3'd1;
    bus.pattern_in       = '0;
    bus.pattern_length   = '0;
    bus.pattern_valid_in = 1'b0;
    bus.start_in         = 1'b0;
    bus.stop_in          = 1'b0;
    bus.beat_in          = 1'b0;

    repeat (3) tick;
    rst_in = 1'b0;
    check("rst_busy",  int'(bus.busy_out), 0);
    check("rst_event", int'(bus.event_valid_out), 0);
    check("rst_num",   int'(bus.num_balls_out), 0);
    check("rst_error", int'(bus.error_out), 0);
    check("rst_id",    int'(bus.ball_id_out), 0);
    check("rst_hand",  int'(bus.hand_out), 0);

    // start with invalid pattern
    bus.pattern_in = p3; bus.pattern_length = 3'd1; bus.pattern_valid_in = 1'b0;
    bus.start_in = 1'b1;
    tick;
    bus.start_in = 1'b0;
    check("inv_error", int'(bus.error_out), 1);
    check("inv_busy",  int'(bus.busy_out), 0);
    bus.beat_in = 1'b1;
    tick;
    bus.beat_in = 1'b0;
    check("inv_error_pulse", int'(bus.error_out), 0);
    check("idle_beat_event", int'(bus.event_valid_out), 0);

    // valid flag but zero length
    bus.pattern_valid_in = 1'b1; bus.pattern_length = 3'd0; bus.start_in = 1'b1;
    tick;
    bus.start_in = 1'b0;
    check("len0_error", int'(bus.error_out), 1);
    check("len0_busy",  int'(bus.busy_out), 0);

    // "3"
    start_pat("p3", p3, 3'd1, 3);
    for (int k = 0; k < 7; k++) beat("p3", 3, ids3[k], k % 2, 0);
    tick;
    check("p3_event_pulse", int'(bus.event_valid_out), 0);
    check("p3_height_hold", int'(bus.throw_height_out), 3);
    bus.stop_in = 1'b1; bus.beat_in = 1'b1;
    tick;
    bus.stop_in = 1'b0; bus.beat_in = 1'b0;
    check("stopbeat_event", int'(bus.event_valid_out), 0);
    check("stopbeat_busy",  int'(bus.busy_out), 0);
    check("stop_num_hold",  int'(bus.num_balls_out), 3);

    // "531"
    start_pat("p531", p531, 3'd3, 3);
    for (int k = 0; k < 7; k++) beat("p531", hs531[k], ids531[k], k % 2, 0);
    stop_play;

    // "40"
    start_pat("p40", p40, 3'd2, 2);
    for (int k = 0; k < 5; k++) beat("p40", hs40[k], ids40[k], k % 2, 0);
    stop_play;

    // reset mid-run, with a beat in the same cycle
    start_pat("p531r", p531, 3'd3, 3);
    for (int k = 0; k < 4; k++) beat("p531r", hs531[k], ids531[k], k % 2, 0);
    rst_in = 1'b1; bus.beat_in = 1'b1;
    tick;
    rst_in = 1'b0; bus.beat_in = 1'b0;
    check("midrst_event", int'(bus.event_valid_out), 0);
    check("midrst_busy",  int'(bus.busy_out), 0);
    check("midrst_hand",  int'(bus.hand_out), 0);
    check("midrst_num",   int'(bus.num_balls_out), 0);
    start_pat("p531s", p531, 3'd3, 3);
    for (int k = 0; k < 3; k++) beat("p531s", hs531[k], ids531[k], k % 2, 0);
    stop_play;

    // "21" forced through: second beat needs a ball that does not exist
    start_pat("p21", p21, 3'd2, 1);
    bus.beat_in = 1'b1;
    tick;
    bus.beat_in = 1'b0;
    check("p21_b0_error", int'(bus.error_out), 0);
    bus.beat_in = 1'b1;
    tick;
    bus.beat_in = 1'b0;
    check("p21_b1_error",  int'(bus.error_out), 1);
    check("p21_b1_height", int'(bus.throw_height_out), 1);
    tick;
    check("p21_error_pulse", int'(bus.error_out), 0);
    check("p21_busy_after_err", int'(bus.busy_out), 1);
    stop_play;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
